parking_sensor_conditioner: RTL and testbench
=============================================

// Module: parking_sensor_conditioner
//
// PURPOSE
// Front-end stage for the car-park sensor array. It takes the raw, asynchronous and bouncy
// presence sensors and synchronises each one into clk. Each channel is then debounced.
// Outputs: clean occupancy levels, one-cycle arrive/depart pulses, and a registered
// occupied-space count. The pulses feed the downstream parking-space status logic directly,
// so that logic never sees glitches or metastable edges.
//
// PARAMETERS
// NUM_SENSORS      8   number of parking-space sensors (channels), >= 1
// SYNC_STAGES      2   flip-flops in each input synchroniser chain, >= 2
// DEBOUNCE_CYCLES  16  consecutive cycles a new level must persist before acceptance, >= 1
//
// PORTS
// clk             in   1                         system clock; all state on rising edge
// rst_n           in   1                         asynchronous, active-low reset
// sensors_raw     in   NUM_SENSORS               raw sensor inputs, asynchronous to clk
// sensors_clean   out  NUM_SENSORS               debounced occupancy level per space
// arrive_pulse    out  NUM_SENSORS               1-cycle pulse when clean[i] goes 0->1
// depart_pulse    out  NUM_SENSORS               1-cycle pulse when clean[i] goes 1->0
// occupied_count  out  $clog2(NUM_SENSORS+1)     popcount of sensors_clean
// change_valid    out  1                         1-cycle pulse; any arrive or depart this cycle
//
// BEHAVIOUR
// - Reset: one clock, asynchronous active-low rst_n. While rst_n=0, every flop is 0: sync
//   chains, counters, sensors_clean, both pulse vectors, occupied_count and change_valid.
// - Sync: raw[i] passes through SYNC_STAGES flops; the last stage is synced[i].
// - Debounce, per channel, with counter cnt[i] of width $clog2(DEBOUNCE_CYCLES) (minimum 1).
//   Each rising edge applies exactly one of these rules:
//   * synced[i]==clean[i]: cnt[i] <= 0.
//   * synced[i]!=clean[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   * synced[i]!=clean[i] and cnt[i]==DEBOUNCE_CYCLES-1: clean[i] <= synced[i] and
//     cnt[i] <= 0.
// - The counter never wraps. Any single matching cycle restarts the qualification.
// - Latency: clean[i] changes on rising edge SYNC_STAGES+DEBOUNCE_CYCLES. Edge 1 is the first
//   edge that samples the new raw level, and raw must be held stable throughout.
// - Pulses: arrive_pulse and depart_pulse are registered. They assert high for exactly one
//   cycle, in the same cycle sensors_clean shows the new value. arrive_pulse[i] and
//   depart_pulse[i] are never high together.
// - change_valid equals OR of (arrive_pulse | depart_pulse), registered alongside them.
// - occupied_count is registered popcount(sensors_clean). It lags sensors_clean by 1 cycle.
// - Channels are fully independent. Simultaneous events on several channels all pulse in the
//   same cycle, and the count reflects the net change one cycle later.
// - A raw pulse shorter than DEBOUNCE_CYCLES synced cycles produces no output change.
//   Continuous bounce produces no change until the input settles.
// - Reset mid-debounce discards partial counts. After release, qualification restarts from
//   cnt=0 and clean=0. If raw is high at release, an arrive pulse follows after full latency.
//
// STRUCTURE
// - Shared package parking_pkg:
//   * NUM_SPACES constant (8).
//   * count-width function clog2p1(n) = $clog2(n+1).
// - Sub-module sensor_debounce_channel: one synchroniser, counter, clean flop and edge-pulse
//   pair. It is instantiated NUM_SENSORS times by a generate loop.
// - Top level holds the popcount and the change_valid logic only.
//
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, NUM_SENSORS=8)
// 1. Reset:
//    - Hold rst_n=0 with raw=8'hFF: all outputs stay 0.
//    - Release rst_n: clean=8'hFF on edge 6, arrive_pulse=8'hFF for 1 cycle,
//      change_valid=1, occupied_count=8 one cycle later.
// 2. Glitch: raw[3] high for 3 cycles, then low -> clean, pulses and count unchanged.
// 3. Single arrival and departure on raw[0]:
//    - Raw rises and holds: clean[0]=1 on edge 6, arrive_pulse=8'h01 for exactly 1 cycle.
//    - Raw later falls: depart_pulse=8'h01 on edge 6 after the fall, count returns to 0.
// 4. Simultaneous events, from clean=8'hF0:
//    - Drop raw[7:4] and raise raw[1] in the same cycle.
//    - Required: depart_pulse=8'hF0 and arrive_pulse=8'h02 in the same cycle, then count 4->1.
// 5. Bounce and mid-debounce reset:
//    - raw[2] toggles every 2 cycles for 20 cycles, then holds 1: exactly one arrive pulse,
//      6 edges after settling.
//    - Separately, assert rst_n while cnt=2: no pulse after release with raw low.

Source files
------------

// File: rtl/parking_pkg.sv
// +----------------------------------------------------------------------------+
// | parking_pkg: shared constants and helpers for the car-park sensor front end|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package parking_pkg;

   localparam int NUM_SPACES = 8;

   // Width needed to hold a count from 0 to n inclusive.
   function automatic int clog2p1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_debounce_channel.sv
// +----------------------------------------------------------------------------+
// | sensor_debounce_channel: synchroniser, debounce counter and edge pulses    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sensor_debounce_channel #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic clean_o,
   output logic arrive_o,
   output logic depart_o,
   output logic event_o
);

   localparam int              CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   arrive_q, arrive_d;
   logic                   depart_q, depart_d;
   logic                   synced;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
      synced   = sync_q[SYNC_STAGES-1];
      cnt_d    = '0;
      clean_d  = clean_q;
      arrive_d = 1'b0;
      depart_d = 1'b0;
      // Any cycle where the synced level matches clean restarts qualification.
      if (synced != clean_q) begin
         if (cnt_q == CNT_MAX) begin
            clean_d  = synced;
            arrive_d = synced;
            depart_d = ~synced;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         clean_q  <= 1'b0;
         arrive_q <= 1'b0;
         depart_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         arrive_q <= arrive_d;
         depart_q <= depart_d;
      end
   end

   assign clean_o  = clean_q;
   assign arrive_o = arrive_q;
   assign depart_o = depart_q;
   // Next-cycle event, so the top can register change_valid alongside the pulses.
   assign event_o  = arrive_d | depart_d;

endmodule

`default_nettype wire

// File: rtl/parking_sensor_conditioner.sv
// +----------------------------------------------------------------------------+
// | parking_sensor_conditioner: per-space debounce plus occupancy count/change |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module parking_sensor_conditioner
   import parking_pkg::*;
#(
   parameter int NUM_SENSORS     = NUM_SPACES,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_SENSORS-1:0]               sensors_raw,
   output logic [NUM_SENSORS-1:0]               sensors_clean,
   output logic [NUM_SENSORS-1:0]               arrive_pulse,
   output logic [NUM_SENSORS-1:0]               depart_pulse,
   output logic [clog2p1(NUM_SENSORS)-1:0]      occupied_count,
   output logic                                 change_valid
);

   localparam int CNT_W = clog2p1(NUM_SENSORS);

   logic [NUM_SENSORS-1:0] event_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   change_q, change_d;

   for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_channel
      sensor_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_channel (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (sensors_raw[g]),
         .clean_o  (sensors_clean[g]),
         .arrive_o (arrive_pulse[g]),
         .depart_o (depart_pulse[g]),
         .event_o  (event_d[g])
      );
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         count_d = count_d + CNT_W'(sensors_clean[i]);
      end
      change_d = |event_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         change_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         change_q <= change_d;
      end
   end

   assign occupied_count = count_q;
   assign change_valid   = change_q;

endmodule

`default_nettype wire

// File: tb/tb_parking_sensor_conditioner.sv
// +----------------------------------------------------------------------------+
// | tb_parking_sensor_conditioner: directed + random bench with delay-line model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_parking_sensor_conditioner;

   localparam int N = 8;
   localparam int S = 2;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] sensors_raw = '1;
   logic [N-1:0] sensors_clean, arrive_pulse, depart_pulse;
   logic [3:0]   occupied_count;
   logic         change_valid;

   parking_sensor_conditioner #(
      .NUM_SENSORS     (N),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sensors_raw    (sensors_raw),
      .sensors_clean  (sensors_clean),
      .arrive_pulse   (arrive_pulse),
      .depart_pulse   (depart_pulse),
      .occupied_count (occupied_count),
      .change_valid   (change_valid)
   );

   always #5 clk = ~clk;

   int n_vectors    = 0;
   int n_miscompares = 0;

   // Reference: raw samples travel a S-deep delay line; a channel flips once the
   // delayed level has disagreed with clean for D consecutive edges.
   logic [N-1:0] m_line [S];
   logic [N-1:0] m_clean, m_arr, m_dep;
   logic         m_chg;
   int           m_count;
   int           m_run [N];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [N-1:0] raw);
      logic [N-1:0] delayed;
      if (!rst_n) begin
         for (int k = 0; k < S; k++) m_line[k] = '0;
         for (int i = 0; i < N; i++) m_run[i] = 0;
         m_clean = '0; m_arr = '0; m_dep = '0; m_chg = 1'b0; m_count = 0;
         return;
      end
      delayed = m_line[S-1];
      m_count = $countones(m_clean);
      m_arr   = '0;
      m_dep   = '0;
      for (int i = 0; i < N; i++) begin
         if (delayed[i] == m_clean[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == D) begin
               m_clean[i] = delayed[i];
               if (delayed[i]) m_arr[i] = 1'b1;
               else            m_dep[i] = 1'b1;
               m_run[i] = 0;
            end
         end
      end
      m_chg = |(m_arr | m_dep);
      for (int k = S - 1; k > 0; k--) m_line[k] = m_line[k-1];
      m_line[0] = raw;
   endtask

   // Called just after a falling edge; drives raw, checks after the next rising edge.
   task automatic tick(input logic [N-1:0] raw, input string tag);
      sensors_raw = raw;
      @(posedge clk);
      #1;
      model_edge(raw);
      check_value({tag, "_clean"},  32'(sensors_clean),  32'(m_clean));
      check_value({tag, "_arrive"}, 32'(arrive_pulse),   32'(m_arr));
      check_value({tag, "_depart"}, 32'(depart_pulse),   32'(m_dep));
      check_value({tag, "_count"},  32'(occupied_count), 32'(m_count));
      check_value({tag, "_change"}, 32'(change_valid),   32'(m_chg));
      @(negedge clk);
   endtask

   logic [N-1:0] lvl;
   int           hold [N];
   int           arrivals;

   initial begin
      @(negedge clk);

      // Reset held with all sensors high, then release.
      for (int c = 0; c < 4; c++) tick(8'hFF, "rst_hold");
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick(8'hFF, "rst_rel");
         if (e == 5) check_value("rst_edge5_clean", 32'(sensors_clean), 32'h00);
         if (e == 6) begin
            check_value("rst_edge6_clean",  32'(sensors_clean), 32'hFF);
            check_value("rst_edge6_arrive", 32'(arrive_pulse),  32'hFF);
            check_value("rst_edge6_change", 32'(change_valid),  32'h1);
         end
         if (e == 7) begin
            check_value("rst_edge7_count",  32'(occupied_count), 32'd8);
            check_value("rst_edge7_arrive", 32'(arrive_pulse),   32'h00);
         end
      end
      for (int c = 0; c < 10; c++) tick(8'h00, "clear");

      // Short glitch on one channel.
      for (int c = 0; c < 3; c++)  tick(8'h08, "glitch");
      for (int c = 0; c < 10; c++) tick(8'h00, "glitch_after");
      check_value("glitch_clean", 32'(sensors_clean), 32'h00);

      // Single arrival then departure.
      for (int c = 0; c < 10; c++) tick(8'h01, "arrive0");
      for (int c = 0; c < 10; c++) tick(8'h00, "depart0");

      // Simultaneous departures and an arrival from clean=F0.
      for (int c = 0; c < 10; c++) tick(8'hF0, "simul_setup");
      for (int c = 0; c < 10; c++) tick(8'h02, "simul");
      for (int c = 0; c < 10; c++) tick(8'h00, "simul_clear");

      // Bounce then settle high: exactly one arrival.
      arrivals = 0;
      for (int c = 0; c < 20; c++) begin
         tick(((c / 2) % 2 == 0) ? 8'h04 : 8'h00, "bounce");
         arrivals += int'(arrive_pulse[2]);
      end
      for (int c = 0; c < 12; c++) begin
         tick(8'h04, "bounce_settle");
         arrivals += int'(arrive_pulse[2]);
      end
      check_value("bounce_one_arrive", 32'(arrivals), 32'd1);
      for (int c = 0; c < 10; c++) tick(8'h00, "bounce_clear");

      // Reset in the middle of qualification.
      for (int c = 0; c < 4; c++) tick(8'h20, "midrst_pre");
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) tick(8'h00, "midrst_hold");
      rst_n = 1'b1;
      arrivals = 0;
      for (int c = 0; c < 10; c++) begin
         tick(8'h00, "midrst_post");
         arrivals += $countones(arrive_pulse);
      end
      check_value("midrst_no_pulse", 32'(arrivals), 32'd0);

      // Random per-channel hold times with occasional resets.
      lvl = '0;
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               lvl[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 10);
            end
            hold[i]--;
         end
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            tick(lvl, "rand_rst");
            tick(lvl, "rand_rst");
            rst_n = 1'b1;
         end else begin
            tick(lvl, "rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

`default_nettype wire
